ir_packet_tx_param: RTL and testbench

- Parametrised successor of the single-colour IR car transmitter.
- Generates a modulated IR packet in this order: start burst, gap, car-select burst, gap, then one burst and one gap per command bit, MSB first.
- Carrier frequency, burst lengths and command width are all parameters.
- New over the previous generation:
  - explicit SEND/BUSY/DONE handshake;
  - command latched at packet start;
  - optional auto-repeat with a programmable inter-packet wait;
  - exact, cycle-counted segment lengths.
- Sits between the bus peripheral register block and the IR LED pin.

---
 rtl/ir_tx_pkg.sv | 15 +
 rtl/ir_carrier_gen.sv | 26 ++
 rtl/ir_packet_tx_param.sv | 152 +++++++++++++++
 tb/tb_ir_packet_tx_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_tx_pkg.sv
// Shared types and helpers for the parametrised IR packet transmitter.
// Segment and phase encodings plus the carrier half-period calculation.
package ir_tx_pkg;

   typedef enum logic [2:0] {IDLE, START, GAP, SELECT, CMD, WAIT} ir_seg_t;

   // Which segment the current GAP follows; selects the GAP's successor.
   typedef enum logic [1:0] {PH_START, PH_SELECT, PH_BIT} ir_phase_t;

   function automatic int calc_half_div(input int clk_hz, input int carrier_hz);
      if (carrier_hz <= 0) return 0;
      return clk_hz / (2 * carrier_hz);
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Restartable carrier divider: high for the first HALF_DIV cycles of each
// 2*HALF_DIV-cycle period, PERIOD_END on the period's last cycle.
module ir_carrier_gen #(
   parameter int HALF_DIV = 1388
) (
   input  logic CLK,
   input  logic RESET,
   input  logic RESTART,
   output logic CARRIER,
   output logic PERIOD_END
);

   localparam int PERIOD = 2 * HALF_DIV;
   localparam int W      = (PERIOD > 2) ? $clog2(PERIOD) : 1;

   logic [W-1:0] cnt_q;

   assign CARRIER    = (cnt_q < W'(HALF_DIV));
   assign PERIOD_END = (cnt_q == W'(PERIOD - 1));

   always_ff @(posedge CLK) begin
      if (RESET || RESTART || PERIOD_END) cnt_q <= '0;
      else                                cnt_q <= cnt_q + W'(1);
   end

endmodule

// File: rtl/ir_packet_tx_param.sv
// Parametrised IR car transmitter: start/select/command bursts separated by
// gaps, SEND/BUSY/DONE handshake and optional auto-repeat.
module ir_packet_tx_param
   import ir_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ    = 100_000_000,
   parameter int CARRIER_HZ     = 36_000,
   parameter int START_BURST    = 191,
   parameter int GAP_LEN        = 25,
   parameter int SELECT_BURST   = 47,
   parameter int ASSERT_BURST   = 47,
   parameter int DEASSERT_BURST = 22,
   parameter int NUM_CMD_BITS   = 4,
   parameter int REPEAT_WAIT    = 1800,
   parameter int CNT_W          = 12
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NUM_CMD_BITS-1:0] COMMAND,
   input  logic                    SEND,
   input  logic                    REPEAT_EN,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    IR_LED
);

   localparam int HALF_DIV = calc_half_div(CLK_FREQ_HZ, CARRIER_HZ);
   localparam int MAX_LEN  = 1 << CNT_W;
   localparam int IDX_W    = (NUM_CMD_BITS > 1) ? $clog2(NUM_CMD_BITS) : 1;

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_BURST - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] SEL_LAST   = CNT_W'(SELECT_BURST - 1);
   localparam logic [CNT_W-1:0] ASRT_LAST  = CNT_W'(ASSERT_BURST - 1);
   localparam logic [CNT_W-1:0] DASRT_LAST = CNT_W'(DEASSERT_BURST - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(REPEAT_WAIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CMD_BITS - 1);

   if (HALF_DIV < 1) begin : g_bad_div
      $fatal(1, "ir_packet_tx_param: carrier half period must be at least one clock");
   end
   if (NUM_CMD_BITS < 1) begin : g_bad_bits
      $fatal(1, "ir_packet_tx_param: NUM_CMD_BITS must be at least 1");
   end
   if (START_BURST < 1 || START_BURST >= MAX_LEN || GAP_LEN < 1 || GAP_LEN >= MAX_LEN ||
       SELECT_BURST < 1 || SELECT_BURST >= MAX_LEN || ASSERT_BURST < 1 ||
       ASSERT_BURST >= MAX_LEN || DEASSERT_BURST < 1 || DEASSERT_BURST >= MAX_LEN ||
       REPEAT_WAIT < 1 || REPEAT_WAIT >= MAX_LEN) begin : g_bad_len
      $fatal(1, "ir_packet_tx_param: segment lengths must lie in 1 .. 2**CNT_W-1");
   end

   ir_seg_t                 state_q, state_d;
   ir_phase_t               phase_q, phase_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, last_cnt;
   logic [NUM_CMD_BITS-1:0] cmd_q, cmd_d;
   logic                    busy_q, busy_d, led_q;
   logic                    restart, carrier, period_end, seg_last;

   ir_carrier_gen #(.HALF_DIV(HALF_DIV)) u_carrier (
      .CLK       (CLK),
      .RESET     (RESET),
      .RESTART   (restart),
      .CARRIER   (carrier),
      .PERIOD_END(period_end)
   );

   always_comb begin
      last_cnt = '0;
      unique case (state_q)
         START:   last_cnt = START_LAST;
         GAP:     last_cnt = GAP_LAST;
         SELECT:  last_cnt = SEL_LAST;
         CMD:     last_cnt = cmd_q[idx_q] ? ASRT_LAST : DASRT_LAST;
         WAIT:    last_cnt = WAIT_LAST;
         default: last_cnt = '0;
      endcase
   end

   assign seg_last = period_end && (cnt_q == last_cnt);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      busy_d  = busy_q;
      restart = 1'b0;
      DONE    = 1'b0;
      cnt_d   = cnt_q;
      if (state_q != IDLE && period_end) cnt_d = seg_last ? '0 : cnt_q + CNT_W'(1);

      unique case (state_q)
         IDLE: if (SEND) begin
            state_d = START;  cmd_d = COMMAND;  busy_d = 1'b1;  restart = 1'b1;  cnt_d = '0;
         end
         START:  if (seg_last) begin state_d = GAP; phase_d = PH_START;  end
         SELECT: if (seg_last) begin state_d = GAP; phase_d = PH_SELECT; end
         CMD:    if (seg_last) begin state_d = GAP; phase_d = PH_BIT;    end
         GAP: if (seg_last) begin
            unique case (phase_q)
               PH_START:  state_d = SELECT;
               PH_SELECT: begin state_d = CMD; idx_d = LAST_IDX; end
               default: begin
                  if (idx_q == '0) begin
                     DONE    = 1'b1;
                     busy_d  = 1'b0;
                     state_d = REPEAT_EN ? WAIT : IDLE;
                  end else begin
                     state_d = CMD;
                     idx_d   = idx_q - IDX_W'(1);
                  end
               end
            endcase
         end
         WAIT: begin
            // A fresh SEND cuts the wait short; dropping REPEAT_EN abandons it.
            if (SEND || (REPEAT_EN && seg_last)) begin
               state_d = START;  cmd_d = COMMAND;  busy_d = 1'b1;  restart = 1'b1;  cnt_d = '0;
            end else if (!REPEAT_EN) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         phase_q <= PH_START;
         idx_q   <= '0;
         cnt_q   <= '0;
         cmd_q   <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
         led_q   <= carrier && (state_q == START || state_q == SELECT || state_q == CMD);
      end
   end

   assign BUSY   = busy_q;
   assign IR_LED = led_q;

endmodule

// File: tb/tb_ir_packet_tx_param.sv
// Bench for ir_packet_tx_param with a 10-cycle carrier: table-driven packet
// shapes, hand-written handshake/repeat/reset sequences and a randomized run.
module tb_ir_packet_tx_param;

   localparam int P_START = 3, P_GAP = 2, P_SEL = 2, P_ASRT = 2, P_DASRT = 1;
   localparam int P_WAIT = 4, PER = 10, HALF = 5;

   logic       CLK = 1'b0, RESET = 1'b1, SEND = 1'b0, REPEAT_EN = 1'b0;
   logic [1:0] COMMAND = 2'b00;
   logic       BUSY, DONE, IR_LED;

   int tests_run = 0, tests_failed = 0;

   ir_packet_tx_param #(
      .CLK_FREQ_HZ(1000), .CARRIER_HZ(100), .START_BURST(P_START), .GAP_LEN(P_GAP),
      .SELECT_BURST(P_SEL), .ASSERT_BURST(P_ASRT), .DEASSERT_BURST(P_DASRT),
      .NUM_CMD_BITS(2), .REPEAT_WAIT(P_WAIT), .CNT_W(12)
   ) dut (
      .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .SEND(SEND), .REPEAT_EN(REPEAT_EN),
      .BUSY(BUSY), .DONE(DONE), .IR_LED(IR_LED)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int t, run, busy_cnt, led_cnt, done_cnt, first_led, done_idx, last_busy, bad_runs;
   } stats_t;

   function automatic stats_t new_stats();
      stats_t s;
      s = '{default: 0};
      s.first_led = -1; s.done_idx = -1; s.last_busy = -1;
      return s;
   endfunction

   // Observe n cycles at the falling edge; t=0 is the cycle after the SEND edge.
   task automatic observe(input int n, inout stats_t s);
      for (int j = 0; j < n; j++) begin
         @(negedge CLK);
         if (BUSY === 1'b1) begin s.busy_cnt++; s.last_busy = s.t; end
         if (DONE === 1'b1) begin s.done_cnt++; s.done_idx = s.t; end
         if (IR_LED === 1'b1) begin
            s.led_cnt++; s.run++;
            if (s.first_led < 0) s.first_led = s.t;
         end else begin
            if (s.run != 0 && s.run != HALF) s.bad_runs++;
            s.run = 0;
         end
         s.t++;
      end
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic pulse_send(input logic [1:0] c);
      COMMAND = c; SEND = 1'b1;
      @(posedge CLK); #1 SEND = 1'b0;
   endtask

   // Reference model: a packet is a list of carrier periods, each burst or gap.
   int m_mode = 0, m_pos = 0, m_len = 0, m_w = 0;  // mode 0 idle, 1 packet, 2 wait
   bit m_burst[$];

   task automatic m_add(input int n, input bit b);
      for (int k = 0; k < n; k++) m_burst.push_back(b);
   endtask

   task automatic m_start(input logic [1:0] c);
      m_burst.delete();
      m_add(P_START, 1); m_add(P_GAP, 0); m_add(P_SEL, 1); m_add(P_GAP, 0);
      for (int i = 1; i >= 0; i--) begin
         m_add(c[i] ? P_ASRT : P_DASRT, 1);
         m_add(P_GAP, 0);
      end
      m_len = m_burst.size() * PER; m_pos = 0; m_mode = 1;
   endtask

   task automatic m_edge(input logic r, input logic s, input logic rep, input logic [1:0] c);
      if (r) m_mode = 0;
      else if (m_mode == 0) begin
         if (s) m_start(c);
      end else if (m_mode == 1) begin
         m_pos++;
         if (m_pos == m_len) begin
            if (rep) begin m_mode = 2; m_w = 0; end
            else m_mode = 0;
         end
      end else begin
         if (s) m_start(c);
         else if (!rep) m_mode = 0;
         else begin
            m_w++;
            if (m_w == P_WAIT * PER) m_start(c);
         end
      end
   endtask

   function automatic logic m_led();
      int p;
      if (m_mode != 1 || m_pos < 1) return 1'b0;
      p = m_pos - 1;
      return m_burst[p / PER] && ((p % PER) < HALF);
   endfunction

   typedef struct { logic [1:0] cmd; int len; int leds; } vec_t;
   vec_t vecs[4];

   initial begin
      stats_t s;
      logic r_rst, r_send, r_rep;
      logic [1:0] r_cmd;

      vecs[0] = '{2'b10, 160, 40};
      vecs[1] = '{2'b00, 150, 35};
      vecs[2] = '{2'b11, 170, 45};
      vecs[3] = '{2'b01, 160, 40};

      check("half_div_default", ir_tx_pkg::calc_half_div(100_000_000, 36_000), 1388);
      check("half_div_bench", ir_tx_pkg::calc_half_div(1000, 100), HALF);

      repeat (3) step();
      @(negedge CLK);
      check("reset_busy", BUSY, 0);
      check("reset_done", DONE, 0);
      check("reset_led", IR_LED, 0);
      RESET = 1'b0;

      // Packet shape per command value
      for (int i = 0; i < 4; i++) begin
         step();
         pulse_send(vecs[i].cmd);
         s = new_stats();
         observe(220, s);
         check($sformatf("v%0d_busy_len", i), s.busy_cnt, vecs[i].len);
         check($sformatf("v%0d_led_cnt", i), s.led_cnt, vecs[i].leds);
         check($sformatf("v%0d_done_cnt", i), s.done_cnt, 1);
         check($sformatf("v%0d_done_idx", i), s.done_idx, s.last_busy);
         check($sformatf("v%0d_last_busy", i), s.last_busy, vecs[i].len - 1);
         check($sformatf("v%0d_first_led", i), s.first_led, 1);
         check($sformatf("v%0d_pulse_width", i), s.bad_runs, 0);
      end

      // Command changed mid-packet must not alter the packet
      step();
      pulse_send(2'b10);
      s = new_stats();
      observe(20, s);
      COMMAND = 2'b11;
      observe(200, s);
      check("midcmd_busy_len", s.busy_cnt, 160);
      check("midcmd_led_cnt", s.led_cnt, 40);

      // SEND held high, then re-pulsed while busy: still one packet
      step();
      COMMAND = 2'b10; SEND = 1'b1;
      s = new_stats();
      observe(100, s);
      SEND = 1'b0;
      observe(30, s);
      SEND = 1'b1; observe(2, s); SEND = 1'b0;
      observe(150, s);
      check("hold_done_cnt", s.done_cnt, 1);
      check("hold_busy_len", s.busy_cnt, 160);

      // Auto-repeat with a live command re-latched at the end of WAIT
      step();
      REPEAT_EN = 1'b1;
      pulse_send(2'b10);
      s = new_stats();
      observe(160, s);
      check("rep1_busy", s.busy_cnt, 160);
      check("rep1_done", s.done_cnt, 1);
      COMMAND = 2'b11;
      s = new_stats();
      observe(PER * P_WAIT, s);
      check("rep_wait_busy", s.busy_cnt, 0);
      check("rep_wait_led", s.led_cnt, 0);
      s = new_stats();
      observe(170, s);
      check("rep2_busy", s.busy_cnt, 170);
      check("rep2_led", s.led_cnt, 45);
      check("rep2_done", s.done_cnt, 1);
      s = new_stats();
      observe(10, s);
      REPEAT_EN = 1'b0;
      observe(300, s);
      check("rep_stop_busy", s.busy_cnt, 0);
      check("rep_stop_led", s.led_cnt, 0);

      // Reset in the middle of a packet
      step();
      pulse_send(2'b10);
      s = new_stats();
      observe(50, s);
      RESET = 1'b1;
      @(negedge CLK);
      check("midreset_busy", BUSY, 0);
      check("midreset_led", IR_LED, 0);
      check("midreset_done", DONE, 0);
      RESET = 1'b0;
      step();
      pulse_send(2'b10);
      s = new_stats();
      observe(220, s);
      check("after_reset_busy", s.busy_cnt, 160);
      check("after_reset_done", s.done_cnt, 1);
      check("after_reset_led", s.led_cnt, 40);

      // Randomized run against the reference model
      @(negedge CLK);
      RESET = 1'b1; SEND = 1'b0; REPEAT_EN = 1'b0;
      r_rep = 1'b0;
      @(posedge CLK);
      m_edge(1'b1, 1'b0, 1'b0, 2'b00);
      @(negedge CLK);
      for (int c = 0; c < 4000; c++) begin
         r_rst  = ($urandom_range(0, 1999) == 0);
         r_send = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 149) == 0) r_rep = ~r_rep;
         r_cmd  = 2'($urandom_range(0, 3));
         RESET = r_rst; SEND = r_send; REPEAT_EN = r_rep; COMMAND = r_cmd;
         @(posedge CLK);
         m_edge(r_rst, r_send, r_rep, r_cmd);
         @(negedge CLK);
         check($sformatf("rand_busy@%0d", c), BUSY, (m_mode == 1) ? 1 : 0);
         check($sformatf("rand_done@%0d", c), DONE, (m_mode == 1 && m_pos == m_len - 1) ? 1 : 0);
         check($sformatf("rand_led@%0d", c), IR_LED, m_led());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
